// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sipo
// Brief    : 16x-oversampled UART receiver, LSB first, one-entry holding
//            register with valid/ready; optional parity via UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sipo #(
    parameter int CLOCK_FREQ = 16000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int WIDTH      = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    output logic             busy
);
    localparam int c_div   = CLOCK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_div_w = $clog2(c_div) + 1;
    localparam int c_tck_w = $clog2(OVERSAMPLE) + 1;
    localparam int c_bit_w = $clog2(WIDTH) + 1;
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(c_div - 1);
    localparam logic [c_tck_w-1:0] c_half_last = c_tck_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tck_w-1:0] c_os_last   = c_tck_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_rx_prev;
    logic               w_rx_s;
    logic               w_fall;
    logic [c_div_w-1:0] r_div;
    logic [c_tck_w-1:0] r_tick_cnt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic               w_tick;
    logic               w_mid_start;
    logic               w_mid_bit;
    logic [WIDTH-1:0]   r_shift;
    logic               r_done;
    logic               r_frame_err;
    logic               r_overrun;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_data_valid;
    logic               w_par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s      = r_sync2;
    assign w_fall      = r_rx_prev & ~w_rx_s;
    assign w_tick      = (r_div == c_div_last);
    assign w_mid_start = w_tick && (r_tick_cnt == c_half_last);
    assign w_mid_bit   = w_tick && (r_tick_cnt == c_os_last);

    // Counters sit at zero while idle so the first tick is aligned to the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
        end else if (r_state == S_IDLE || r_state == S_BREAK) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if ((r_state == S_START && w_mid_start) || w_mid_bit)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_next = S_START;
            S_START:  if (w_mid_start) w_state_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_mid_bit && r_bit_cnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_mid_bit) w_state_next = S_STOP;
`endif
            S_STOP:   if (w_mid_bit) w_state_next = w_rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (w_rx_s) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == S_IDLE)
                r_bit_cnt <= '0;
            if (r_state == S_DATA && w_mid_bit) begin
                r_shift   <= {w_rx_s, r_shift[WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == S_STOP && w_mid_bit) begin
                if (!w_rx_s)
                    r_frame_err <= 1'b1;
                else
                    r_done <= ~w_par_bad;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_exp;

    assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            if (r_state == S_IDLE) begin
                r_par_bad <= 1'b0;
            end else if (r_state == S_PARITY && w_mid_bit && (w_rx_s != w_par_exp)) begin
                r_par_bad    <= 1'b1;
                r_parity_err <= 1'b1;
            end
        end
    end

    assign w_par_bad  = r_par_bad;
    assign parity_err = r_parity_err;
`else
    // Parity sense has no role when the parity stage is compiled out.
    logic w_unused_par;
    assign w_unused_par = (PARITY_ODD != 0);
    assign w_par_bad    = 1'b0;
    assign parity_err   = 1'b0;
`endif

    // A completing byte may replace the held one only if it is being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_data_valid || data_ready) begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sipo
// Brief    : Self-checking bench for uart_rx_sipo with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;
    localparam int CLOCK_FREQ = 2000000;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int WIDTH      = 8;
    localparam int PARITY_ODD = 0;
    localparam int c_div      = CLOCK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_bit      = c_div * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam int c_np = 1;
`else
    localparam int c_np = 0;
`endif
    // First clk edge that sees the start bit -> edge sampling mid-stop:
    // 2 sync flops, 1 edge-detect register, then half a bit plus all later bits.
    localparam int c_stop_ofs = 2 + c_bit / 2 + (WIDTH + 1 + c_np) * c_bit;

    logic             clk;
    logic             rst_n;
    logic             rx_in;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;
    logic             busy;

    uart_rx_sipo #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .WIDTH      (WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               n_tests;
    int               n_fail;
    int               cyc;
    int               f_start [64];
    logic [WIDTH-1:0] f_data  [64];
    logic             f_par   [64];
    logic             f_stop  [64];
    int               n_frames;

    int               rd;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ferr;
    logic             exp_ovr;
    logic             exp_perr;
    logic             m_load;
    logic             m_bad_par;
    logic [WIDTH-1:0] m_byte;
    int               m_s;
    int               ferr_seen;
    int               ovr_seen;
    int               perr_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model plus per-cycle comparison.
    initial begin : compare
        cyc       = 0;
        rd        = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        ferr_seen = 0;
        ovr_seen  = 0;
        perr_seen = 0;
        forever begin
            @(posedge clk);
            cyc++;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            exp_perr = 1'b0;
            m_load   = 1'b0;
            if (!rst_n) begin
                exp_valid = 1'b0;
                exp_data  = '0;
                rd        = n_frames;
            end else begin
                if (rd < n_frames) begin
                    m_s       = f_start[rd] + c_stop_ofs;
                    m_bad_par = (c_np == 1) &&
                                (f_par[rd] != ((^f_data[rd]) ^ (PARITY_ODD != 0)));
                    m_byte    = f_data[rd];
                    if (cyc == m_s - c_bit && m_bad_par)
                        exp_perr = 1'b1;
                    if (cyc == m_s && !f_stop[rd]) begin
                        exp_ferr = 1'b1;
                        rd++;
                    end else if (cyc == m_s && m_bad_par) begin
                        rd++;
                    end else if (cyc == m_s + 1) begin
                        m_load = 1'b1;
                        rd++;
                    end
                end
                if (m_load) begin
                    if (!exp_valid || data_ready) begin
                        exp_valid = 1'b1;
                        exp_data  = m_byte;
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end else if (data_ready) begin
                    exp_valid = 1'b0;
                end
            end
            #1;
            check("data_valid", 32'(data_valid), 32'(exp_valid));
            check("data_out",   32'(data_out),   32'(exp_data));
            check("frame_err",  32'(frame_err),  32'(exp_ferr));
            check("overrun",    32'(overrun),    32'(exp_ovr));
            check("parity_err", 32'(parity_err), 32'(exp_perr));
            if (frame_err)  ferr_seen++;
            if (overrun)    ovr_seen++;
            if (parity_err) perr_seen++;
        end
    end

    task automatic send_frame(input logic [WIDTH-1:0] d, input logic par, input logic stp);
        f_start[n_frames] = cyc + 1;
        f_data[n_frames]  = d;
        f_par[n_frames]   = par;
        f_stop[n_frames]  = stp;
        n_frames++;
        rx_in = 1'b0;
        repeat (c_bit) @(negedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            rx_in = d[i];
            repeat (c_bit) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par;
        repeat (c_bit) @(negedge clk);
`endif
        rx_in = stp;
        repeat (c_bit) @(negedge clk);
    endtask

    task automatic pulse_ready();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin : stim
        int         p0;
        logic [7:0] b;
        n_tests    = 0;
        n_fail     = 0;
        n_frames   = 0;
        rst_n      = 1'b0;
        rx_in      = 1'b1;
        data_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data",  32'(data_out),   32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 3 of an abandoned frame.
        b = 8'hC3;
        f_start[n_frames] = cyc + 1;
        f_data[n_frames]  = b;
        f_par[n_frames]   = 1'b0;
        f_stop[n_frames]  = 1'b1;
        n_frames++;
        rx_in = 1'b0;
        repeat (c_bit) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = b[i];
            repeat (c_bit) @(negedge clk);
        end
        rx_in = b[3];
        repeat (c_bit / 2) @(negedge clk);
        check("midframe_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_busy",  32'(busy),       32'd0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("after_rst_data",  32'(data_out),   32'h5A);
        check("after_rst_valid", 32'(data_valid), 32'd1);
        pulse_ready();
        check("after_rst_clear", 32'(data_valid), 32'd0);

        // Single frame held until consumed.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_data", 32'(data_out), 32'hA5);
        repeat (3 * c_bit) @(negedge clk);
        check("a5_held", 32'(data_valid), 32'd1);
        pulse_ready();
        check("a5_clear", 32'(data_valid), 32'd0);

        // False start shorter than half a bit.
        rx_in = 1'b0;
        repeat (50) @(negedge clk);
        rx_in = 1'b1;
        check("fstart_busy_on", 32'(busy), 32'd1);
        repeat (c_bit) @(negedge clk);
        check("fstart_busy_off", 32'(busy),       32'd0);
        check("fstart_valid",    32'(data_valid), 32'd0);

        // Framing error followed by a long break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20 * c_bit) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * c_bit) @(negedge clk);
        check("ferr_count", 32'(ferr_seen),  32'd1);
        check("ferr_valid", 32'(data_valid), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1);
        check("post_break_data", 32'(data_out), 32'h81);
        pulse_ready();

        // Overrun: second byte dropped while the first is held.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ovr_data",  32'(data_out), 32'h11);
        check("ovr_count", 32'(ovr_seen), 32'd1);
        // Same situation but consumed on the completion edge.
        p0 = cyc + 1;
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                while (cyc != p0 + c_stop_ofs) @(negedge clk);
                pulse_ready();
            end
        join
        check("swap_data",  32'(data_out),   32'h22);
        check("swap_valid", 32'(data_valid), 32'd1);
        check("swap_ovr",   32'(ovr_seen),   32'd1);
        pulse_ready();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (c_bit) @(negedge clk);
        check("par_bad_count", 32'(perr_seen),  32'd1);
        check("par_bad_valid", 32'(data_valid), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_data", 32'(data_out), 32'h07);
`endif

        repeat (2 * c_bit) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- Serial-in, parallel-out UART receiver. It is the receive-side counterpart of the existing LSB-first PISO transmitter (1 start bit, WIDTH data bits LSB first, 1 stop bit, line idles high).
- Samples the serial line using 16x oversampling derived from the system clock.
- Delivers each received byte through a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns. Its byte output feeds a fifo_buff write side in the hub.

Parameters:
- CLOCK_FREQ, 16000000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- OVERSAMPLE, 16, ticks per bit. Must be even and at least 8.
- WIDTH, 8, data bits per frame.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd). Ignored otherwise.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rx_in, input, 1, raw asynchronous serial line.
- data_out, output, WIDTH, received byte from the holding register.
- data_valid, output, 1, holding register is full.
- data_ready, input, 1, consumer accepts data_out on a clk edge where data_valid=1.
- frame_err, output, 1, one-cycle pulse: stop bit sampled as 0.
- overrun, output, 1, one-cycle pulse: a completed byte was dropped.
- parity_err, output, 1, one-cycle pulse: parity mismatch. Constant 0 when the feature is compiled out.
- busy, output, 1, 1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous; takes effect mid-frame too):
  - FSM goes to IDLE.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
  - Both synchronizer flops preset to 1. Dividers and shift register cleared.
- Input path: rx_in passes through a 2-flop synchronizer to give rx_s. Total input latency is 2 clk.
- Tick generator:
  - DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE), integer truncated (104 at defaults). The divider counter has width CLOG2(DIV)+1.
  - One tick = a 1-clk pulse every DIV clk.
  - The divider and the tick counter (width CLOG2(OVERSAMPLE)+1) are cleared on leaving IDLE, so sampling is aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, BREAK.
  - IDLE: a falling edge on rx_s (previous 1, current 0) enters START and clears the counters.
  - START: at tick count OVERSAMPLE/2 (mid-bit):
    - rx_s=1 is a false start: return to IDLE with no outputs.
    - rx_s=0 goes to DATA and resets the tick count.
  - DATA: at every OVERSAMPLE ticks (mid-bit), shift rx_s into the MSB of the shift register (right shift, so the LSB is received first). After WIDTH samples, go to PARITY if the feature is enabled, otherwise STOP.
  - PARITY: one mid-bit sample, compared against the XOR of the data bits (inverted if PARITY_ODD). Then go to STOP.
  - STOP: at the mid-bit sample:
    - rx_s=1 completes the byte; go to IDLE.
    - rx_s=0 pulses frame_err, discards the byte and goes to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. No further frame_err pulses during a held-low line.
- Byte completion (good stop, and parity OK if enabled) happens 1 clk after the stop sample edge:
  - data_valid=0, or data_ready=1 in the same cycle: load data_out and set data_valid=1.
  - data_valid=1 and data_ready=0: keep the old byte and pulse overrun.
- A parity error pulses parity_err and discards the byte; it does not cause overrun.
- Handshake:
  - data_valid stays high until a clk edge with data_ready=1, then clears, unless a new byte completes on the same edge (it then stays 1 with the new data_out).
  - data_out is stable while data_valid=1.
  - data_ready while data_valid=0 has no effect.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA, and parity_err is driven as above.
- Undefined: no PARITY state, frame length is 1+WIDTH+1 bits, and parity_err is tied to 0.

Test Plan:
- Reset behaviour: rst_n=0 mid-frame (during DATA bit 3), then release with rx_in=1 -> all outputs 0, busy=0, and the next frame 0x5A is received correctly.
- Single frame: 0xA5 at 9600 baud (bit time 1664 clk) with data_ready=0 -> data_out=0xA5 and data_valid=1 about 9.5 bit times after the start edge. Valid is held until data_ready=1 for one clk, then data_valid=0.
- False start: rx_in low for 400 clk, then high -> no data_valid and no error pulses; busy returns to 0 and FSM is back in IDLE.
- Framing error: 0x3C with stop bit 0 -> one frame_err pulse, data_valid stays 0. Line then held low for 20 bit times (still exactly one pulse), released, then 0x81 -> data_out=0x81.
- Overrun: 0x11 then 0x22 back to back with data_ready=0 -> data_out=0x11 and one overrun pulse at the second stop. A second run with data_ready=1 on the completion cycle -> data_out=0x22 and no overrun.
- With UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err pulse, no data_valid. 0x07 with parity bit 1 -> data_out=0x07.
